display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Sequencer that sits in front of the Gray-to-7-segment datapath (top).
//  Debounces and synchronises the 4 raw Gray switches and commits a stable
//  code to the datapath. Time-multiplexes the shared segment bus between the
//  units and decades digits by driving the datapath's show_decades select and
//  the active-low digit enables, inserting a blanking gap between digits.
//  Optionally blanks the decades digit for values below 10.
// PARAMETERS
//  DEBOUNCE_CYCLES  270000  consecutive stable synced cycles before commit (>=1)
//  REFRESH_DIV      27000   cycles each digit is lit per scan slot (>=1)
//  GAP_CYCLES       4       all-digits-off cycles between slots (>=1)
//  BLANK_LEADING    1       1: decades digit off when committed value <= 9
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  rst_n         in   1  synchronous reset, active low
//  gray_in       in   4  raw asynchronous Gray switches
//  gray_code     out  4  committed Gray code to datapath gray_code
//  show_decades  out  1  datapath digit select: 1 = decades, 0 = units
//  an_n          out  2  digit enables, active low; [0] = units, [1] = decades
//  code_update   out  1  1-cycle pulse when gray_code takes a new, different value
// BEHAVIOUR
//  Reset (rst_n==0 at an edge): sync FFs=0, cand=0, deb_cnt=0, gray_code=0,
//   code_update=0, state=GAP_D, slot_cnt=0, show_decades=0, an_n=2'b11.
//   Reset applies mid-debounce or mid-scan with no exceptions.
//  Synchroniser: 2-FF chain, s2 = gray_in delayed 2 edges.
//  Debounce, evaluated per edge:
//   - s2 != cand: cand<=s2, deb_cnt<=0.
//   - else deb_cnt==DEBOUNCE_CYCLES-1: gray_code<=cand, deb_cnt holds (saturates).
//   - else: deb_cnt<=deb_cnt+1.
//   - Commit pulses code_update only if cand != gray_code; commit happens once.
//   - Latency: an input change first sampled at edge 1 appears on gray_code
//     at edge DEBOUNCE_CYCLES+3 if held; any change restarts the count.
//  Value for blanking: bin = gray2bin(gray_code); ge10 = (bin >= 10). 4-bit
//   Gray covers 0..15. This computation is internal only.
//  Scan FSM; slot_cnt clears on every state change:
//   UNITS  : lasts REFRESH_DIV cycles; show_decades=0, an_n=2'b10; -> GAP_U
//   GAP_U  : lasts GAP_CYCLES;  show_decades=1, an_n=2'b11;        -> DECADES
//   DECADES: lasts REFRESH_DIV; show_decades=1;
//            an_n=2'b01, or 2'b11 if BLANK_LEADING && !ge10;       -> GAP_D
//   GAP_D  : lasts GAP_CYCLES;  show_decades=0, an_n=2'b11;        -> UNITS
//   - Transition when slot_cnt == len-1; slot_cnt wraps to 0.
//   - Outputs are registered and reflect the current state.
//   - show_decades changes only while an_n==2'b11, so there is no ghosting.
//  Simultaneous commit and slot change: both take effect at the same edge.
//   Blanking uses the new gray_code from the following cycle.
// TESTING (DEBOUNCE_CYCLES=3, REFRESH_DIV=4, GAP_CYCLES=1 unless noted)
//  1. Hold rst_n=0 for 2 edges, then release with gray_in=0 -> outputs at
//     reset values. After release: an_n 11 (1 cyc), 10 (4 cyc, sd=0),
//     11 (1 cyc, sd=1), then 11 for 4 cyc (value 0 blanked).
//  2. gray_in 0000->1111 and held -> gray_code=1111 at edge 6;
//     code_update=1 for exactly that cycle; next DECADES slot an_n=01.
//  3. gray_in pulses to 0001 for 2 cycles, then returns to 0000 ->
//     gray_code stays 0000 and code_update never asserts.
//  4. Toggle gray_in 0000/0011 every 2 cycles for 10 cycles, then hold
//     0011 -> single commit exactly 6 edges after the last change.
//  5. BLANK_LEADING=0, gray_in=0 -> DECADES slot drives an_n=01, sd=1.
//  6. Assert rst_n=0 mid-DECADES with gray_code=1111 -> next edge:
//     an_n=11, sd=0, gray_code=0; the scan restarts from GAP_D.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Debounces the Gray switches into a committed code and time-multiplexes the
// shared segment bus between the units and decades digits with blanking gaps.
module display_scan_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REFRESH_DIV     = 27000,
  parameter int GAP_CYCLES      = 4,
  parameter bit BLANK_LEADING   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] gray_in,
  output logic [3:0] gray_code,
  output logic       show_decades,
  output logic [1:0] an_n,
  output logic       code_update
);

  localparam int DEB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SLOT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SLOT_W-1:0] REFRESH_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] GAP_LAST     = SLOT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    UNITS,
    GAP_U,
    DECADES,
    GAP_D
  } scan_state_t;

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       cand;
  logic [DEB_W-1:0] deb_cnt;

  scan_state_t      state;
  scan_state_t      next_state;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_last;
  logic             slot_done;
  logic             next_show_decades;
  logic [1:0]       next_an_n;
  logic [3:0]       bin;
  logic             ge10;

  // Counter saturates once the candidate is committed, so a held code commits once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      cand        <= '0;
      deb_cnt     <= '0;
      gray_code   <= '0;
      code_update <= 1'b0;
    end else begin
      sync1       <= gray_in;
      sync2       <= sync1;
      code_update <= 1'b0;
      if (sync2 != cand) begin
        cand    <= sync2;
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        gray_code   <= cand;
        code_update <= (cand != gray_code);
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bin[3] = gray_code[3];
    bin[2] = ^gray_code[3:2];
    bin[1] = ^gray_code[3:1];
    bin[0] = ^gray_code[3:0];
    ge10   = (bin >= 4'd10);
  end

  // Outputs are decoded from the next state so they are registered with it.
  always_comb begin
    next_state        = state;
    next_show_decades = 1'b0;
    next_an_n         = 2'b11;
    slot_last         = ((state == UNITS) || (state == DECADES)) ? REFRESH_LAST : GAP_LAST;
    slot_done         = (slot_cnt == slot_last);

    if (slot_done) begin
      case (state)
        UNITS:   next_state = GAP_U;
        GAP_U:   next_state = DECADES;
        DECADES: next_state = GAP_D;
        GAP_D:   next_state = UNITS;
        default: next_state = GAP_D;
      endcase
    end

    case (next_state)
      UNITS: begin
        next_an_n = 2'b10;
      end
      GAP_U: begin
        next_show_decades = 1'b1;
      end
      DECADES: begin
        next_show_decades = 1'b1;
        next_an_n         = (BLANK_LEADING && !ge10) ? 2'b11 : 2'b01;
      end
      default: begin
        next_show_decades = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= GAP_D;
      slot_cnt     <= '0;
      show_decades <= 1'b0;
      an_n         <= 2'b11;
    end else begin
      state        <= next_state;
      slot_cnt     <= slot_done ? '0 : slot_cnt + 1'b1;
      show_decades <= next_show_decades;
      an_n         <= next_an_n;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed scan and commit expectations,
// negedge monitors pop and compare them against two DUTs (blanking on and off).
module tb_display_scan_ctrl;

  typedef struct {
    int         cyc;
    int         unit;
    logic [1:0] an;
    logic       sd;
    logic [3:0] gc;
  } scan_exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] gc;
  } commit_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gray_in;
  logic [3:0] gray_code;
  logic       show_decades;
  logic [1:0] an_n;
  logic       code_update;
  logic [3:0] nb_gray_code;
  logic       nb_show_decades;
  logic [1:0] nb_an_n;
  logic       nb_code_update;

  int cyc = 0;
  int n_compared = 0;
  int n_mismatched = 0;

  scan_exp_t   scan_q[$];
  commit_exp_t commit_q[$];

  localparam int R  = 2;
  localparam int R2 = R + 58;

  display_scan_ctrl #(
    .DEBOUNCE_CYCLES(3), .REFRESH_DIV(4), .GAP_CYCLES(1), .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_code(gray_code),
    .show_decades(show_decades), .an_n(an_n), .code_update(code_update)
  );

  display_scan_ctrl #(
    .DEBOUNCE_CYCLES(3), .REFRESH_DIV(4), .GAP_CYCLES(1), .BLANK_LEADING(1'b0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_code(nb_gray_code),
    .show_decades(nb_show_decades), .an_n(nb_an_n), .code_update(nb_code_update)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expect_scan(input int c, input int unit, input logic [1:0] an,
                             input logic sd, input logic [3:0] gc);
    scan_exp_t e;
    e.cyc = c; e.unit = unit; e.an = an; e.sd = sd; e.gc = gc;
    scan_q.push_back(e);
  endtask

  task automatic expect_commit(input int c, input logic [3:0] gc);
    commit_exp_t e;
    e.cyc = c; e.gc = gc;
    commit_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic apply_stimulus(input int at, input logic [3:0] val);
    wait_cyc(at);
    gray_in = val;
  endtask

  // Scan monitor: entries may be pushed out of order, so match by cycle.
  always @(negedge clk) begin
    for (int i = scan_q.size() - 1; i >= 0; i--) begin
      if (scan_q[i].cyc == cyc) begin
        logic [6:0] act;
        logic [6:0] exp_v;
        exp_v = {scan_q[i].an, scan_q[i].sd, scan_q[i].gc};
        if (scan_q[i].unit == 0) act = {an_n, show_decades, gray_code};
        else                     act = {nb_an_n, nb_show_decades, nb_gray_code};
        check_output($sformatf("scan cyc=%0d dut%0d {an_n,sd,gray_code}",
                               cyc, scan_q[i].unit), 64'(act), 64'(exp_v));
        scan_q.delete(i);
      end
    end
  end

  // Commit monitor: every code_update pulse must match the next queued commit.
  always @(negedge clk) begin
    if (rst_n === 1'b1 || cyc >= R) begin
      if (code_update === 1'b1) begin
        if (commit_q.size() == 0) begin
          check_output($sformatf("unexpected code_update cyc=%0d", cyc), 64'(1), 64'(0));
        end else begin
          commit_exp_t e;
          e = commit_q.pop_front();
          check_output("commit cycle", 64'(cyc), 64'(e.cyc));
          check_output("commit gray_code", 64'(gray_code), 64'(e.gc));
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    gray_in = 4'b0000;

    // Reset values, first scan period, blanked decades, and the unblanked twin.
    expect_scan(R, 0, 2'b11, 1'b0, 4'h0);
    for (int c = R + 1; c <= R + 4; c++) expect_scan(c, 0, 2'b10, 1'b0, 4'h0);
    expect_scan(R + 5, 0, 2'b11, 1'b1, 4'h0);
    for (int c = R + 6; c <= R + 9; c++) expect_scan(c, 0, 2'b11, 1'b1, 4'h0);
    expect_scan(R + 10, 0, 2'b11, 1'b0, 4'h0);
    expect_scan(R, 1, 2'b11, 1'b0, 4'h0);
    for (int c = R + 6; c <= R + 9; c++) expect_scan(c, 1, 2'b01, 1'b1, 4'h0);
    expect_scan(R + 11, 1, 2'b10, 1'b0, 4'h0);

    wait_cyc(R);
    rst_n = 1'b1;
    $display("[TB] reset released at cycle %0d", cyc);

    // Two-cycle glitch must not commit.
    apply_stimulus(R + 2, 4'b0001);
    apply_stimulus(R + 4, 4'b0000);

    // Held 1111 commits on the same edge the scan enters DECADES.
    expect_commit(R + 16, 4'b1111);
    expect_scan(R + 15, 0, 2'b11, 1'b1, 4'h0);
    expect_scan(R + 16, 0, 2'b11, 1'b1, 4'hF);
    for (int c = R + 17; c <= R + 19; c++) expect_scan(c, 0, 2'b01, 1'b1, 4'hF);
    expect_scan(R + 20, 0, 2'b11, 1'b0, 4'hF);
    expect_scan(R + 21, 0, 2'b10, 1'b0, 4'hF);
    apply_stimulus(R + 10, 4'b1111);

    // Bouncing input restarts the count; commit 6 edges after the last change.
    expect_scan(R + 36, 0, 2'b01, 1'b1, 4'hF);
    expect_scan(R + 39, 0, 2'b01, 1'b1, 4'hF);
    expect_scan(R + 45, 0, 2'b11, 1'b1, 4'hF);
    expect_commit(R + 46, 4'b0011);
    expect_scan(R + 46, 0, 2'b01, 1'b1, 4'h3);
    expect_scan(R + 47, 0, 2'b11, 1'b1, 4'h3);
    expect_scan(R + 49, 0, 2'b11, 1'b1, 4'h3);
    expect_scan(R + 50, 0, 2'b11, 1'b0, 4'h3);
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(R + 30 + 2 * k, (k % 2 == 0) ? 4'b0000 : 4'b0011);
    end

    // Commit 1111 again, then reset in the middle of DECADES.
    expect_commit(R + 56, 4'b1111);
    expect_scan(R + 56, 0, 2'b11, 1'b1, 4'hF);
    expect_scan(R + 57, 0, 2'b01, 1'b1, 4'hF);
    expect_scan(R + 58, 0, 2'b11, 1'b0, 4'h0);
    expect_scan(R2 + 1, 0, 2'b10, 1'b0, 4'h0);
    expect_scan(R2 + 4, 0, 2'b10, 1'b0, 4'h0);
    expect_scan(R2 + 5, 0, 2'b11, 1'b1, 4'h0);
    expect_scan(R2 + 6, 0, 2'b11, 1'b1, 4'h0);
    apply_stimulus(R + 50, 4'b1111);

    wait_cyc(R + 57);
    rst_n   = 1'b0;
    gray_in = 4'b0000;
    wait_cyc(R + 58);
    rst_n = 1'b1;

    wait_cyc(R2 + 12);
    #1;
    check_output("scan entries left unchecked", 64'(scan_q.size()), 64'(0));
    check_output("commits never seen", 64'(commit_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
